// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_pkg
// Description : Shared definitions for the instruction fetch stage:
//               - FSM state encoding
//               - default address and data widths
//               - the halt instruction encoding
//               - the default reset PC
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

  localparam int IF_ADDR_W = 10;
  localparam int IF_DATA_W = 32;

  localparam logic [IF_ADDR_W-1:0] IF_RESET_PC  = 10'd0;
  localparam logic [IF_DATA_W-1:0] IF_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } if_state_t;

endpackage : instruction_fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_if_id_register.sv
`default_nettype none
// ============================================================================
// Module      : if_id_register
// Description : IF/ID pipeline register. It holds the fetched instruction,
//               the address it came from, and a valid flag.
//               Update priority, highest first:
//                 clear : drop VALID; INSTR and PC_OUT keep their values
//                 hold  : keep every field unchanged
//                 load  : capture instr_in and pc_in, set VALID
//               When none of these is asserted, all fields hold.
// Ports       : clk      - clock, rising edge
//               reset_n  - synchronous active-low reset
//               load     - capture instr_in / pc_in and set valid
//               clear    - clear valid
//               hold     - keep all fields unchanged
//               instr_in - instruction word to capture
//               pc_in    - address the word was read from
//               instr    - registered instruction
//               pc_out   - registered fetch address
//               valid    - registered valid flag
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_register #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              clear,
  input  logic              hold,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc_out,
  output logic              valid
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr  <= '0;
      pc_out <= '0;
      valid  <= 1'b0;
    end else if (clear) begin
      // The squashed slot keeps stale INSTR/PC_OUT; only VALID matters.
      valid <= 1'b0;
    end else if (!hold && load) begin
      instr  <= instr_in;
      pc_out <= pc_in;
      valid  <= 1'b1;
    end
  end

endmodule : if_id_register
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Fetch stage in front of a combinational 1024-word
//               instruction memory. It owns the PC and the fetch FSM
//               (IDLE / FETCH / HALT), and feeds the IF/ID register.
//               In FETCH, the priority on each clock edge is:
//                 1. redirect (BRANCH_TAKEN)
//                 2. stall (STALL)
//                 3. advance
//               Fetching the halt word delivers it once and then freezes
//               the PC.
// Ports       : CLK           - clock, rising edge
//               RESET         - synchronous active-low reset
//               START         - pulse that leaves IDLE
//               STALL         - decode back-pressure
//               BRANCH_TAKEN  - redirect request
//               BRANCH_TARGET - redirect destination
//               IM_ADDRESS    - instruction memory address (current PC)
//               IM_Q          - instruction memory read data
//               INSTR         - IF/ID instruction
//               PC_OUT        - IF/ID fetch address
//               VALID         - IF/ID holds a live instruction
//               HALTED        - fetch stopped on the halt word
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                ADDR_W    = IF_ADDR_W,
  parameter int                DATA_W    = IF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(IF_RESET_PC),
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(IF_HALT_WORD)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              STALL,
  input  logic              BRANCH_TAKEN,
  input  logic [ADDR_W-1:0] BRANCH_TARGET,
  output logic [ADDR_W-1:0] IM_ADDRESS,
  input  logic [DATA_W-1:0] IM_Q,
  output logic [DATA_W-1:0] INSTR,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic              VALID,
  output logic              HALTED
);

  if_state_t         state;
  if_state_t         next_state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              halted;
  logic              next_halted;
  logic              ifid_load;
  logic              ifid_clear;
  logic              ifid_hold;
  logic              is_halt_word;

  assign is_halt_word = (IM_Q == HALT_WORD);

  // State, PC and halt flag registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state  <= ST_IDLE;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else begin
      state  <= next_state;
      pc     <= next_pc;
      halted <= next_halted;
    end
  end

  // Next-state, next-PC and IF/ID control.
  always_comb begin
    next_state  = state;
    next_pc     = pc;
    next_halted = halted;
    ifid_load   = 1'b0;
    ifid_clear  = 1'b0;
    ifid_hold   = 1'b1;

    case (state)
      ST_IDLE: begin
        // Only START matters here; STALL and BRANCH_TAKEN are ignored.
        if (START) begin
          next_state = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (BRANCH_TAKEN) begin
          // A redirect wins over a stall; the word on IM_Q is squashed.
          next_pc    = BRANCH_TARGET;
          ifid_clear = 1'b1;
        end else if (!STALL) begin
          ifid_hold = 1'b0;
          ifid_load = 1'b1;
          if (is_halt_word) begin
            // Deliver the halt word and freeze the PC on its address.
            next_state  = ST_HALT;
            next_halted = 1'b1;
          end else begin
            // Wraps modulo 2^ADDR_W.
            next_pc = pc + ADDR_W'(1);
          end
        end
      end

      ST_HALT: begin
        if (BRANCH_TAKEN) begin
          // An older instruction redirects, so the halt was on a wrong path.
          next_pc     = BRANCH_TARGET;
          next_state  = ST_FETCH;
          next_halted = 1'b0;
          ifid_clear  = 1'b1;
        end else if (!STALL) begin
          // The halt word has been consumed by decode; retire it.
          ifid_clear = 1'b1;
        end
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  if_id_register #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id_register (
    .clk      (CLK),
    .reset_n  (RESET),
    .load     (ifid_load),
    .clear    (ifid_clear),
    .hold     (ifid_hold),
    .instr_in (IM_Q),
    .pc_in    (pc),
    .instr    (INSTR),
    .pc_out   (PC_OUT),
    .valid    (VALID)
  );

  assign IM_ADDRESS = pc;
  assign HALTED     = halted;

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed self-checking bench for instruction_fetch. It models
//               a combinational instruction memory and compares the outputs
//               one time unit after each rising clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;
  localparam logic [31:0] WORD_A = 32'hAAAA_0001;
  localparam logic [31:0] WORD_B = 32'hBBBB_0002;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [9:0]  BRANCH_TARGET;
  logic [9:0]  IM_ADDRESS;
  logic [31:0] IM_Q;
  logic [31:0] INSTR;
  logic [9:0]  PC_OUT;
  logic        VALID;
  logic        HALTED;

  logic [31:0] mem [1024];
  int          total;
  int          bad;

  assign IM_Q = mem[IM_ADDRESS];

  instruction_fetch dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .START         (START),
    .STALL         (STALL),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .IM_ADDRESS    (IM_ADDRESS),
    .IM_Q          (IM_Q),
    .INSTR         (INSTR),
    .PC_OUT        (PC_OUT),
    .VALID         (VALID),
    .HALTED        (HALTED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] ins, input logic [9:0] pco,
                            input logic vld);
    check({tag, ".instr"}, INSTR, ins);
    check({tag, ".pc_out"}, {22'd0, PC_OUT}, {22'd0, pco});
    check({tag, ".valid"}, {31'd0, VALID}, {31'd0, vld});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".addr"}, {22'd0, IM_ADDRESS}, 32'd0);
    check({tag, ".instr"}, INSTR, 32'd0);
    check({tag, ".pc_out"}, {22'd0, PC_OUT}, 32'd0);
    check({tag, ".valid"}, {31'd0, VALID}, 32'd0);
    check({tag, ".halted"}, {31'd0, HALTED}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]    = 32'd11;
    mem[1]    = 32'd22;
    mem[2]    = 32'd33;
    mem[3]    = 32'd44;
    mem[10]   = HALT;
    mem[1022] = WORD_A;
    mem[1023] = WORD_B;

    RESET = 1'b0; START = 1'b0; STALL = 1'b0;
    BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 10'd0;

    // 1: reset, idle without START, then a straight-line run.
    step(); step();
    check_reset_vals("rst");
    RESET = 1'b1;
    // STALL and BRANCH_TAKEN must be ignored while idle.
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 10'd300;
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset_vals("idle");
    end
    BRANCH_TAKEN = 1'b0;
    START = 1'b1;
    step();
    START = 1'b0;
    check("start.addr", {22'd0, IM_ADDRESS}, 32'd0);
    check("start.valid", {31'd0, VALID}, 32'd0);
    step(); check_ifid("run0", 32'd11, 10'd0, 1'b1);
    step(); check_ifid("run1", 32'd22, 10'd1, 1'b1);
    step(); check_ifid("run2", 32'd33, 10'd2, 1'b1);
    // START during FETCH is ignored.
    START = 1'b1;
    step(); check_ifid("run3", 32'd44, 10'd3, 1'b1);
    START = 1'b0;
    step(); check_ifid("run4", mem[4], 10'd4, 1'b1);
    check("run4.addr", {22'd0, IM_ADDRESS}, 32'd5);

    // 2: stall at PC=5.
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.addr", {22'd0, IM_ADDRESS}, 32'd5);
      check_ifid("stall", mem[4], 10'd4, 1'b1);
    end
    STALL = 1'b0;
    step(); check_ifid("unstall5", mem[5], 10'd5, 1'b1);
    step(); check_ifid("run6", mem[6], 10'd6, 1'b1);
    step(); check_ifid("run7", mem[7], 10'd7, 1'b1);
    check("run7.addr", {22'd0, IM_ADDRESS}, 32'd8);

    // 3: redirect to 100 with a simultaneous stall.
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 10'd100; STALL = 1'b1;
    step();
    BRANCH_TAKEN = 1'b0; STALL = 1'b0;
    check("br.addr", {22'd0, IM_ADDRESS}, 32'd100);
    check("br.valid", {31'd0, VALID}, 32'd0);
    step(); check_ifid("br100", mem[100], 10'd100, 1'b1);

    // 4: wrap from 1023 to 0.
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 10'd1022;
    step();
    BRANCH_TAKEN = 1'b0;
    check("wr.addr", {22'd0, IM_ADDRESS}, 32'd1022);
    check("wr.valid", {31'd0, VALID}, 32'd0);
    step(); check_ifid("wrA", WORD_A, 10'd1022, 1'b1);
    step(); check_ifid("wrB", WORD_B, 10'd1023, 1'b1);
    step(); check_ifid("wrC", 32'd11, 10'd0, 1'b1);
    for (int i = 1; i < 10; i++) begin
      step();
      check_ifid("seq", mem[i], 10'(i), 1'b1);
    end

    // 5: halt word at address 10.
    step();
    check_ifid("halt", HALT, 10'd10, 1'b1);
    check("halt.halted", {31'd0, HALTED}, 32'd1);
    check("halt.addr", {22'd0, IM_ADDRESS}, 32'd10);
    for (int i = 0; i < 5; i++) begin
      // A START pulse while halted is ignored.
      START = (i == 2);
      step();
      check("halted.valid", {31'd0, VALID}, 32'd0);
      check("halted.flag", {31'd0, HALTED}, 32'd1);
      check("halted.addr", {22'd0, IM_ADDRESS}, 32'd10);
    end
    START = 1'b0;
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 10'd20;
    step();
    BRANCH_TAKEN = 1'b0;
    check("unhalt.flag", {31'd0, HALTED}, 32'd0);
    check("unhalt.addr", {22'd0, IM_ADDRESS}, 32'd20);
    check("unhalt.valid", {31'd0, VALID}, 32'd0);
    step(); check_ifid("unhalt20", mem[20], 10'd20, 1'b1);

    // 6a: reset while halted.
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 10'd10;
    step();
    BRANCH_TAKEN = 1'b0;
    step();
    check("rehalt.flag", {31'd0, HALTED}, 32'd1);
    step();
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    check_reset_vals("rst_halt");
    step(); step();
    check_reset_vals("rst_halt_idle");
    START = 1'b1;
    step();
    START = 1'b0;
    step(); check_ifid("resume0", 32'd11, 10'd0, 1'b1);
    step(); check_ifid("resume1", 32'd22, 10'd1, 1'b1);

    // 6b: reset in the middle of a stall.
    STALL = 1'b1;
    step();
    check_ifid("midstall", 32'd22, 10'd1, 1'b1);
    RESET = 1'b0;
    step();
    RESET = 1'b1; STALL = 1'b0;
    check_reset_vals("rst_stall");
    step(); step();
    check_reset_vals("rst_stall_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the bench always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule : tb_instruction_fetch
`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory's 10-bit word ADDRESS.
- Captures the combinational read word Q into an IF/ID register, with stall, branch/jump redirect, squash, start and halt control.
- Output feeds the decode stage.

Parameters:
- ADDR_W, 10, PC/address width (word-addressed, matches the 1024-word instruction memory).
- DATA_W, 32, instruction width.
- RESET_PC, 10'd0, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.

Ports:
- CLK  input  1  single clock, all state updates on posedge.
- RESET  input  1  synchronous, active-low reset (sampled on posedge CLK; 0 = reset).
- START  input  1  one-cycle pulse; leaves IDLE and begins fetching.
- STALL  input  1  hold PC and IF/ID register (decode back-pressure).
- BRANCH_TAKEN  input  1  redirect request from a later stage.
- BRANCH_TARGET  input  ADDR_W  redirect destination.
- IM_ADDRESS  output  ADDR_W  address to instruction memory; equals current PC.
- IM_Q  input  DATA_W  combinational read data from instruction memory.
- INSTR  output  DATA_W  IF/ID instruction register.
- PC_OUT  output  ADDR_W  address INSTR was fetched from.
- VALID  output  1  INSTR/PC_OUT hold a live instruction.
- HALTED  output  1  fetch stopped on HALT_WORD.

Behaviour:
- Reset (RESET==0 at posedge) overrides everything. It sets:
  - state=IDLE, PC=RESET_PC (so IM_ADDRESS=RESET_PC)
  - INSTR=0, PC_OUT=0, VALID=0, HALTED=0
- States:
  - IDLE: PC held, VALID=0. STALL and BRANCH_TAKEN are ignored. START -> FETCH.
  - FETCH: normal operation.
  - HALT: PC frozen, HALTED=1.
- FETCH priority per posedge: BRANCH_TAKEN > STALL > advance.
  - Advance: INSTR<=IM_Q, PC_OUT<=PC, VALID<=1, PC<=PC+1.
  - PC+1 wraps modulo 2^ADDR_W: 1023 -> 0, no flag.
  - Redirect: PC<=BRANCH_TARGET, VALID<=0. The word currently on IM_Q is squashed. INSTR/PC_OUT are don't-care and hold.
  - Stall with no redirect: PC, INSTR, PC_OUT and VALID all hold.
  - Redirect with STALL high in the same cycle: the redirect wins, so the PC is updated and VALID clears.
- Latency: the word at address A appears on INSTR with VALID=1 one cycle after IM_ADDRESS==A, provided there is no stall or redirect. Sustained throughput is one instruction per cycle.
- Halt:
  - On an advance where IM_Q==HALT_WORD, the halt word is delivered normally (INSTR=HALT_WORD, VALID=1, PC_OUT=A).
  - PC stays at A (no increment), state -> HALT, HALTED<=1.
- In HALT:
  - The next non-stalled cycle clears VALID. The halt word is delivered exactly once.
  - While STALL is high, VALID holds.
  - BRANCH_TAKEN (an older instruction redirecting): PC<=BRANCH_TARGET, VALID<=0, HALTED<=0, state -> FETCH. The wrong-path halt is discarded.
  - START is ignored.
- A HALT_WORD arriving in a redirect or stall cycle is not captured and does not halt.
- START while in FETCH is ignored.
- Reset mid-operation (any state, including stalled or halted) returns to IDLE with the reset values on the next edge. There is no partial state.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, FETCH=2'd1, HALT=2'd2)
  - ADDR_W and DATA_W defaults
  - HALT_WORD constant
  - the default RESET_PC
- One natural sub-module: if_id_register, which holds INSTR, PC_OUT and VALID.
  - Inputs: load, clear and hold.
  - Synchronous active-low reset.
- The PC, next-PC mux and FSM stay in instruction_fetch.

Test Plan:
1. Reset low 2 cycles, then high, no START.
   -> IM_ADDRESS=0, VALID=0, HALTED=0 indefinitely.
   Then pulse START with words 0..3 = 11,22,33,44.
   -> INSTR 11,22,33,44 on consecutive cycles, PC_OUT 0..3, VALID=1.
2. Running at PC=5, assert STALL 3 cycles.
   -> IM_ADDRESS=5 and INSTR/PC_OUT/VALID frozen.
   Release.
   -> next cycle INSTR=mem[5], PC_OUT=5.
3. At PC=8, BRANCH_TAKEN=1 with target 100, STALL=1 in the same cycle.
   -> next cycle IM_ADDRESS=100, VALID=0.
   -> following cycle INSTR=mem[100], PC_OUT=100.
4. Start at PC=1022 with words A,B at 1022,1023 and C at 0.
   -> PC_OUT sequence 1022,1023,0 and INSTR A,B,C.
5. Word 10 = HALT_WORD.
   -> INSTR=HALT_WORD, VALID=1, PC_OUT=10 once; then VALID=0, HALTED=1, IM_ADDRESS stays 10 for 5+ cycles.
   Then BRANCH_TAKEN to 20.
   -> HALTED=0, next cycle INSTR=mem[20].
6. RESET low while halted, and separately mid-stall.
   -> next edge: IDLE with all reset values (IM_ADDRESS=RESET_PC, VALID=0, HALTED=0).
   START is required to resume.
